bash_f_const_rev_gen: RTL

Reverse-order round-constant generator for the bash-f permutation. It derives the constant sequence C_ROUNDS, C_ROUNDS-1, …, C1 from the fixed seed C1 and issues one constant per valid/ready handshake. It feeds the round datapath of the inverse bash-f permutation, which consumes constants last-round-first. It is the counterpart of the forward one-step constant update, and it contains both the forward step (to reach C_ROUNDS) and the inverse step (to walk back down).

---
 rtl/bash_f_const_rev_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bash_f_const_rev_gen.sv
// Reverse-order round-constant generator for the bash-f permutation.
// Starts from the seed C1 and steps forward to C_ROUNDS. It then walks back
// down to C1, issuing one constant per valid/ready handshake.
// Optional self-check: define BASH_CONST_REV_CHECK_EN to build the end-of-run
// comparator that drives err_o. When it is undefined, err_o is tied low.
module bash_f_const_rev_gen #(
  parameter int unsigned ROUNDS  = 24,
  parameter logic [63:0] C_FIRST = 64'hB194BAC80A08F53B
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  output logic                            ready_o,
  output logic [63:0]                     const_o,
  output logic                            const_valid_o,
  input  logic                            const_ready_i,
  output logic [$clog2(ROUNDS+1)-1:0]     round_o,
  output logic                            last_o,
  output logic                            done_o,
  output logic                            err_o
);

  localparam int RW = $clog2(ROUNDS + 1);

  // Convert between byte-ordered port form and the integer view (self-inverse).
  function automatic logic [63:0] bswap(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int k = 0; k < 8; k++) y[63-8*k -: 8] = x[8*k +: 8];
    return y;
  endfunction

  localparam logic [63:0] C_BO  = 64'hAED8E07F99E12BDC;
  localparam logic [63:0] C_INT = bswap(C_BO);

  // One forward LFSR-style step, byte-ordered in and out.
  function automatic logic [63:0] f_step(input logic [63:0] b);
    logic [63:0] x;
    x = bswap(b);
    x = (x >> 1) ^ (x[0] ? C_INT : 64'd0);
    return bswap(x);
  endfunction

  // Inverse step: C has its MSB set and x >> 1 never does, so bit 63 tells
  // whether C was folded in.
  function automatic logic [63:0] i_step(input logic [63:0] b);
    logic [63:0] x;
    x = bswap(b);
    x = x[63] ? (((x ^ C_INT) << 1) | 64'd1) : (x << 1);
    return bswap(x);
  endfunction

  typedef enum logic [1:0] {IDLE, WARM, EMIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [63:0]   cst_q, cst_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          emit;

`ifdef BASH_CONST_REV_CHECK_EN
  logic err_q, err_d;
`endif

  // Next-state logic: warm up forward to C_ROUNDS, then walk back on handshakes.
  always_comb begin
    state_d = state_q;
    cst_d   = cst_q;
    cnt_d   = cnt_q;
`ifdef BASH_CONST_REV_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cst_d   = C_FIRST;
          cnt_d   = RW'(1);
          state_d = (ROUNDS == 1) ? EMIT : WARM;
`ifdef BASH_CONST_REV_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      WARM: begin
        cst_d = f_step(cst_q);
        cnt_d = cnt_q + RW'(1);
        if (cnt_q == RW'(ROUNDS - 1)) state_d = EMIT;
      end
      EMIT: begin
        if (const_ready_i) begin
          if (cnt_q > RW'(1)) begin
            cst_d = i_step(cst_q);
            cnt_d = cnt_q - RW'(1);
          end else begin
            state_d = DONE;
`ifdef BASH_CONST_REV_CHECK_EN
            // The walk back must land exactly on the seed.
            if (cst_q != C_FIRST) err_d = 1'b1;
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, constant and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cst_q   <= cst_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BASH_CONST_REV_CHECK_EN
  // Sticky error flag, cleared by reset or an accepted start.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Outputs decode registered state only; nothing depends on const_ready_i.
  assign emit          = (state_q == EMIT);
  assign ready_o       = (state_q == IDLE);
  assign const_valid_o = emit;
  assign const_o       = emit ? cst_q : '0;
  assign round_o       = emit ? cnt_q : '0;
  assign last_o        = emit && (cnt_q == RW'(1));
  assign done_o        = (state_q == DONE);

endmodule
